// File: rtl/ddr_align_pkg.sv
// Shared types and defaults for the DDR lane alignment sequencer.
// Optional feature macro: DDR_PERIODIC_RETRAIN_EN.
package ddr_align_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LOCK   = 3'd1,
    PULSE       = 3'd2,
    WAIT_RESULT = 3'd3,
    NEXT        = 3'd4,
    DONE        = 3'd5,
    ERR         = 3'd6
  } align_state_e;

  localparam int DEF_NUM_LANES      = 4;
  localparam int DEF_LOCK_STABLE    = 64;
  localparam int DEF_RST_PULSE      = 8;
  localparam int DEF_TIMEOUT        = 4096;
  localparam int DEF_MAX_RETRY      = 3;
  localparam int DEF_RETRAIN_PERIOD = 2 ** 20;

  // Bits needed to hold max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ddr_align_lock_sync.sv
// pll_lock 2-flop synchroniser plus lock stability qualifier.
// lock_ok rises once lock_s held LOCK_STABLE cycles while qual_en.
module ddr_align_lock_sync
  import ddr_align_pkg::*;
#(
  parameter int LOCK_STABLE = DEF_LOCK_STABLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic qual_en,
  output logic lock_s,
  output logic lock_ok
);

  localparam int CW = cnt_width(LOCK_STABLE - 1);
  localparam logic [CW-1:0] STABLE_END =
    CW'(LOCK_STABLE - 1);

  logic          lock_meta;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      cnt       <= '0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      if (!qual_en || !lock_s)
        cnt <= '0;
      else if (!lock_ok)
        cnt <= cnt + 1'b1;
    end
  end

  assign lock_ok = (cnt == STABLE_END);

endmodule

// File: rtl/ddr_lane_align_sched.sv
// Sequences per-lane read-alignment training one lane at a time.
// Optional: DDR_PERIODIC_RETRAIN_EN re-trains every RETRAIN_PERIOD in DONE.
module ddr_lane_align_sched
  import ddr_align_pkg::*;
#(
  parameter int NUM_LANES      = DEF_NUM_LANES,
  parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int RST_PULSE      = DEF_RST_PULSE,
  parameter int TIMEOUT        = DEF_TIMEOUT,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int RETRAIN_PERIOD = DEF_RETRAIN_PERIOD,
  localparam int LW = cnt_width(NUM_LANES - 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  input  logic                 init_start,
  input  logic [NUM_LANES-1:0] lane_good,
  input  logic [NUM_LANES-1:0] lane_err,
  output logic [NUM_LANES-1:0] lane_rst_dp,
  output logic                 pattern_en,
  output logic                 train_busy,
  output logic                 train_done,
  output logic                 train_err,
  output logic [LW-1:0]        err_lane
);

  localparam int TMAX1 =
    (TIMEOUT > RST_PULSE) ? TIMEOUT : RST_PULSE;
  localparam int TMAX =
    (RETRAIN_PERIOD > TMAX1) ? RETRAIN_PERIOD : TMAX1;
  localparam int TW = cnt_width(TMAX);
  localparam int RW = cnt_width(MAX_RETRY);

  localparam logic [TW-1:0] PULSE_END = TW'(RST_PULSE - 1);
  localparam logic [TW-1:0] TMO_END   = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
`ifdef DDR_PERIODIC_RETRAIN_EN
  localparam logic [TW-1:0] RETRAIN_END =
    TW'(RETRAIN_PERIOD - 1);
`endif

  align_state_e         state;
  logic [TW-1:0]        timer;
  logic [LW-1:0]        lane_idx;
  logic [LW-1:0]        err_idx;
  logic [RW-1:0]        retry;
  logic [NUM_LANES-1:0] lane_sel;
  logic                 lock_s;
  logic                 lock_ok;
  logic                 qual_en;
  logic                 sel_good;
  logic                 sel_err;
  logic                 in_train;

  assign qual_en = (state == WAIT_LOCK);

  ddr_align_lock_sync #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .pll_lock(pll_lock),
    .qual_en (qual_en),
    .lock_s  (lock_s),
    .lock_ok (lock_ok)
  );

  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < NUM_LANES; i++)
      lane_sel[i] = (lane_idx == LW'(i));
  end

  // Only the selected lane is observed; good wins over err.
  assign sel_good = |(lane_good & lane_sel);
  assign sel_err  = |(lane_err & lane_sel);
  assign in_train = (state == PULSE)
                 || (state == WAIT_RESULT)
                 || (state == NEXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      lane_idx    <= '0;
      retry       <= '0;
      err_idx     <= '0;
      lane_rst_dp <= '0;
      pattern_en  <= 1'b0;
      train_busy  <= 1'b0;
      train_done  <= 1'b0;
      train_err   <= 1'b0;
      err_lane    <= '0;
    end else begin
      lane_rst_dp <= (state == PULSE) ? lane_sel : '0;
      pattern_en  <= in_train;
      train_busy  <= in_train || (state == WAIT_LOCK);
      train_done  <= (state == DONE);
      train_err   <= (state == ERR);
      err_lane    <= (state == ERR) ? err_idx : '0;
      if (timer != '1)
        timer <= timer + 1'b1;
      if (in_train && !lock_s) begin
        state    <= WAIT_LOCK;
        timer    <= '0;
        lane_idx <= '0;
        retry    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (init_start) begin
              state <= WAIT_LOCK;
              timer <= '0;
            end
          end
          WAIT_LOCK: begin
            if (lock_ok) begin
              state    <= PULSE;
              timer    <= '0;
              lane_idx <= '0;
              retry    <= '0;
            end
          end
          PULSE: begin
            if (timer == PULSE_END) begin
              state <= WAIT_RESULT;
              timer <= '0;
            end
          end
          WAIT_RESULT: begin
            if (sel_good) begin
              state <= NEXT;
              timer <= '0;
            end else if (sel_err || timer == TMO_END) begin
              timer <= '0;
              if (retry < RETRY_MAX) begin
                retry <= retry + 1'b1;
                state <= PULSE;
              end else begin
                state   <= ERR;
                err_idx <= lane_idx;
              end
            end
          end
          NEXT: begin
            timer <= '0;
            if (lane_idx == LAST_LANE) begin
              state <= DONE;
            end else begin
              lane_idx <= lane_idx + 1'b1;
              retry    <= '0;
              state    <= PULSE;
            end
          end
          DONE: begin
            if (!lock_s || init_start) begin
              state <= WAIT_LOCK;
              timer <= '0;
            end
`ifdef DDR_PERIODIC_RETRAIN_EN
            else if (timer == RETRAIN_END) begin
              state    <= PULSE;
              timer    <= '0;
              lane_idx <= '0;
              retry    <= '0;
            end
`endif
          end
          ERR: begin
            if (init_start) begin
              state   <= WAIT_LOCK;
              timer   <= '0;
              err_idx <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_lane_align_sched.sv
// Scoreboard bench for ddr_lane_align_sched: directed lane scenarios.
// Build with or without DDR_PERIODIC_RETRAIN_EN.
module tb_ddr_lane_align_sched;

  localparam int NL = 4;
  localparam int K_PULSE = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int          kind;
    logic [NL-1:0] val;
    int          width;
    int          gap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_lock = 1'b0;
  logic          init_start = 1'b0;
  logic [NL-1:0] lane_good = '0;
  logic [NL-1:0] lane_err = '0;
  logic [NL-1:0] lane_rst_dp;
  logic          pattern_en;
  logic          train_busy;
  logic          train_done;
  logic          train_err;
  logic [1:0]    err_lane;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  ddr_lane_align_sched #(
    .NUM_LANES     (NL),
    .LOCK_STABLE   (64),
    .RST_PULSE     (8),
    .TIMEOUT       (4096),
    .MAX_RETRY     (3),
    .RETRAIN_PERIOD(1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .init_start (init_start),
    .lane_good  (lane_good),
    .lane_err   (lane_err),
    .lane_rst_dp(lane_rst_dp),
    .pattern_en (pattern_en),
    .train_busy (train_busy),
    .train_done (train_done),
    .train_err  (train_err),
    .err_lane   (err_lane)
  );

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d @%0t",
               name, act, exp, $time);
    end
  endfunction

  task automatic exp_pulse(logic [NL-1:0] v, int gap);
    q.push_back('{kind: K_PULSE, val: v, width: 8, gap: gap});
  endtask

  task automatic exp_ev(int kind, logic [NL-1:0] v);
    q.push_back('{kind: kind, val: v, width: 0, gap: -1});
  endtask

  task automatic pop_exp(input int kind, output exp_t e,
                         output bit ok);
    ok = 1'b0;
    e = '{kind: -1, val: '0, width: 0, gap: -1};
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: kind %0d, want none @%0t",
               kind, $time);
    end else begin
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: turns DUT output edges into events, compares in order.
  initial begin : monitor
    logic [NL-1:0] prev_dp;
    logic [NL-1:0] cur;
    logic          prev_done;
    logic          prev_err;
    int            width;
    int            zcnt;
    int            gap;
    exp_t          e;
    bit            ok;
    prev_dp = '0;
    cur = '0;
    prev_done = 1'b0;
    prev_err = 1'b0;
    width = 0;
    zcnt = 0;
    gap = 0;
    wait (rst_n);
    forever begin
      @(negedge clk);
      if (lane_rst_dp != '0 && prev_dp == '0) begin
        cur = lane_rst_dp;
        width = 1;
        gap = zcnt;
      end else if (lane_rst_dp != '0) begin
        width++;
      end else if (prev_dp != '0) begin
        pop_exp(K_PULSE, e, ok);
        if (ok) begin
          check("pulse_val", int'(cur), int'(e.val));
          check("pulse_width", width, e.width);
          if (e.gap >= 0)
            check("pulse_gap", gap, e.gap);
        end
      end
      zcnt = (lane_rst_dp != '0) ? 0 : zcnt + 1;
      if (train_done && !prev_done) begin
        pop_exp(K_DONE, e, ok);
        if (ok) begin
          check("done_pattern_en", int'(pattern_en), 0);
          check("done_busy", int'(train_busy), 0);
        end
      end
      if (train_err && !prev_err) begin
        pop_exp(K_ERR, e, ok);
        if (ok) begin
          check("err_lane", int'(err_lane), int'(e.val));
          check("err_done", int'(train_done), 0);
        end
      end
      prev_dp = lane_rst_dp;
      prev_done = train_done;
      prev_err = train_err;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start();
    init_start = 1'b1;
    cyc(1);
    init_start = 1'b0;
  endtask

  task automatic wait_rise(int lane);
    int n = 0;
    while (!lane_rst_dp[lane] && n < 20000) begin
      cyc(1);
      n++;
    end
    check("rise_seen", int'(lane_rst_dp[lane]), 1);
  endtask

  task automatic good_after(int lane, int dly);
    cyc(dly);
    lane_good[lane] = 1'b1;
    cyc(1);
    lane_good[lane] = 1'b0;
  endtask

  task automatic respond(int lane, int dly);
    wait_rise(lane);
    good_after(lane, dly);
  endtask

  task automatic wait_drain(string name, int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      cyc(1);
      n++;
    end
    check({name, "_drain"}, q.size(), 0);
  endtask

  initial begin : stim
    int n;
    pll_lock = 1'b1;
    cyc(3);
    check("reset_outputs",
          int'({lane_rst_dp, pattern_en, train_busy,
                train_done, train_err, err_lane}), 0);
    rst_n = 1'b1;
    cyc(5);
    check("idle_busy", int'(train_busy), 0);

    // 1: every lane good 100 cycles after its pulse
    exp_pulse(4'b0001, -1);
    exp_pulse(4'b0010, 95);
    exp_pulse(4'b0100, 95);
    exp_pulse(4'b1000, 95);
    exp_ev(K_DONE, '0);
    start();
    for (int i = 0; i < NL; i++)
      respond(i, 100);
    wait_drain("t1", 1000);

    // 2: lane 2 always errors
    lane_good = 4'b0011;
    lane_err  = 4'b0100;
    exp_pulse(4'b0001, -1);
    exp_pulse(4'b0010, 2);
    exp_pulse(4'b0100, 2);
    for (int i = 0; i < 3; i++)
      exp_pulse(4'b0100, 1);
    exp_ev(K_ERR, 4'd2);
    start();
    wait_drain("t2", 600);
    cyc(20);
    check("t2_err_held", int'(train_err), 1);
    check("t2_err_lane", int'(err_lane), 2);

    // 3: lane 1 silent, retries on timeout
    lane_good = 4'b0001;
    lane_err  = 4'b0000;
    exp_pulse(4'b0001, -1);
    exp_pulse(4'b0010, 2);
    for (int i = 0; i < 3; i++)
      exp_pulse(4'b0010, 4096);
    exp_ev(K_ERR, 4'd1);
    start();
    wait_drain("t3", 17500);

    // 4: lock loss while lane 1 awaits its result
    lane_good = 4'b0000;
    exp_pulse(4'b0001, -1);
    exp_pulse(4'b0010, -1);
    exp_pulse(4'b0001, -1);
    exp_pulse(4'b0010, -1);
    exp_pulse(4'b0100, -1);
    exp_pulse(4'b1000, -1);
    exp_ev(K_DONE, '0);
    start();
    respond(0, 20);
    wait_rise(1);
    cyc(20);
    pll_lock = 1'b0;
    cyc(3);
    check("t4_dp_clear", int'(lane_rst_dp), 0);
    cyc(7);
    check("t4_abort_pattern", int'(pattern_en), 0);
    check("t4_abort_busy", int'(train_busy), 1);
    pll_lock = 1'b1;
    n = 0;
    while (!lane_rst_dp[0] && n < 200) begin
      cyc(1);
      n++;
    end
    check("t4_relock_cycles", n, 67);
    good_after(0, 20);
    for (int i = 1; i < NL; i++)
      respond(i, 20);
    wait_drain("t4", 400);

    // 5: good+err together, init_start while busy
    lane_good = 4'b1111;
    lane_err  = 4'b1111;
    exp_pulse(4'b0001, -1);
    exp_pulse(4'b0010, 2);
    exp_pulse(4'b0100, 2);
    exp_pulse(4'b1000, 2);
    exp_ev(K_DONE, '0);
    start();
    cyc(5);
    start();
    wait_rise(1);
    start();
    n = 0;
    while (!train_done && n < 300) begin
      cyc(1);
      n++;
    end
    check("t5_done", int'(train_done), 1);

    // 6: periodic retrain (or none) from DONE
`ifdef DDR_PERIODIC_RETRAIN_EN
    exp_pulse(4'b0001, -1);
    exp_pulse(4'b0010, 2);
    exp_pulse(4'b0100, 2);
    exp_pulse(4'b1000, 2);
    exp_ev(K_DONE, '0);
`endif
    n = 0;
    while (train_done && n < 1500) begin
      cyc(1);
      n++;
    end
`ifdef DDR_PERIODIC_RETRAIN_EN
    check("t6_retrain_cycles", n, 1000);
    check("t6_lane0_pulse", int'(lane_rst_dp), 1);
`else
    check("t6_done_cycles", n, 1500);
    check("t6_done_held", int'(train_done), 1);
`endif
    wait_drain("t6", 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
